svi_rr_arbiter: RTL and testbench

Round-robin arbiter that consumes an array of stream interface instances, `u_S[SIZE-1:0]`, and merges them into one registered output stream. It sits directly downstream of the blocks that drive interface-array members by `assign`/generate loops, closing the loop with a handshake (`ready`) back into each array element. Each beat carries its source index; output latency is one cycle.

---
 rtl/svi_arb_pkg.sv | 23 ++
 rtl/svi_rr_arbiter_rr_pick.sv | 31 +++
 rtl/svi_rr_arbiter.sv | 91 +++++++++
 tb/tb_svi_rr_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/svi_arb_pkg.sv
// svi_arb_pkg: shared constants/types for the round-robin arbiter,
// plus stream interface S (valid/data upstream, ready back).
package svi_arb_pkg;
  localparam int SIZE  = 8;
  localparam int WIDTH = 8;
  localparam int CNT_W = 16;
  localparam int IDX_W = $clog2(SIZE);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [WIDTH-1:0] data_t;
endpackage

// S: one requester stream.
// sink = arbiter side, src = producer side.
interface S;
  import svi_arb_pkg::*;
  logic  valid;
  logic  ready;
  data_t data;

  modport sink (input valid, input data, output ready);
  modport src  (output valid, output data, input ready);
endinterface

// File: rtl/svi_rr_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority selector.
// Ports: i_req (request vector), i_ptr (last grant),
// o_sel (first request after i_ptr), o_any (any request).
module rr_pick import svi_arb_pkg::*; #(
  parameter  int N  = SIZE,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_sel,
  output logic          o_any
);

  logic [IW-1:0] w_j;

  // Scan from farthest to nearest so the nearest
  // request after i_ptr is the last write and wins.
  always_comb begin
    o_sel = i_ptr;
    o_any = 1'b0;
    w_j   = '0;
    for (int k = N; k >= 1; k--) begin
      w_j = IW'((int'(i_ptr) + k) % N);
      if (i_req[w_j]) begin
        o_sel = w_j;
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/svi_rr_arbiter.sv
// svi_rr_arbiter: merges u_S[SIZE] streams into one registered
// output stream with round-robin priority; o_idx = source index.
// Ports: i_clk, i_rst (async, high), u_S[] (sink modport),
// o_valid/i_ready/o_data/o_idx output stream.
// SVI_ARB_CNT_EN adds o_cnt: SIZE x 16-bit saturating
// per-requester grant counters (index k at o_cnt[16k +: 16]).
module svi_rr_arbiter import svi_arb_pkg::CNT_W; #(
  parameter  int SIZE  = svi_arb_pkg::SIZE,
  parameter  int WIDTH = svi_arb_pkg::WIDTH,
  localparam int IW    = $clog2(SIZE)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  S.sink                   u_S [SIZE-1:0],
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [IW-1:0]    o_idx
`ifdef SVI_ARB_CNT_EN
  ,
  output logic [SIZE*CNT_W-1:0] o_cnt
`endif
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    r_ptr;

  logic             w_load;
  logic             w_any;
  logic             w_take;
  logic [IW-1:0]    w_sel;
  logic [SIZE-1:0]  w_req;
  logic [WIDTH-1:0] w_dat [SIZE];

  assign w_load = !r_valid || i_ready;
  assign w_take = w_load && w_any;

  for (genvar g = 0; g < SIZE; g++) begin : g_req
    assign w_req[g]      = u_S[g].valid;
    assign w_dat[g]      = u_S[g].data;
    assign u_S[g].ready  = w_take && (w_sel == IW'(g));
  end

  rr_pick #(.N(SIZE)) u_pick (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_sel (w_sel),
    .o_any (w_any)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
      r_ptr   <= IW'(SIZE - 1);
    end else if (w_load) begin
      if (w_any) begin
        r_valid <= 1'b1;
        r_data  <= w_dat[w_sel];
        r_idx   <= w_sel;
        r_ptr   <= w_sel;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_idx   = r_idx;

`ifdef SVI_ARB_CNT_EN
  logic [CNT_W-1:0] r_cnt [SIZE];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < SIZE; k++) r_cnt[k] <= '0;
    end else if (w_take && (r_cnt[w_sel] != '1)) begin
      r_cnt[w_sel] <= r_cnt[w_sel] + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < SIZE; g++) begin : g_cnt
    assign o_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
  end
`endif

endmodule

// File: tb/tb_svi_rr_arbiter.sv
// tb_svi_rr_arbiter: directed + randomized checks of the
// round-robin arbiter against a behavioural model.
module tb_svi_rr_arbiter;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       t_rdy_in = 1'b0;
  logic [7:0] t_v = '0;
  logic [7:0] t_d [N];
  wire  [7:0] rv;
  logic       o_valid;
  logic [7:0] o_data;
  logic [2:0] o_idx;
`ifdef SVI_ARB_CNT_EN
  logic [N*16-1:0] o_cnt;
`endif

  int total = 0;
  int bad   = 0;

  S u_s [N-1:0] ();

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign u_s[g].valid = t_v[g];
    assign u_s[g].data  = t_d[g];
    assign rv[g]        = u_s[g].ready;
  end

  svi_rr_arbiter dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .u_S     (u_s),
    .o_valid (o_valid),
    .i_ready (t_rdy_in),
    .o_data  (o_data),
    .o_idx   (o_idx)
`ifdef SVI_ARB_CNT_EN
    ,
    .o_cnt   (o_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: pointer, output beat, counters.
  int         m_ptr;
  bit         m_ov;
  logic [7:0] m_od;
  logic [2:0] m_oi;
  bit         m_load;
  bit         m_any;
  int         m_sel;
  logic [7:0] m_rdy;
  int         m_cnt [N];

  task automatic m_reset();
    m_ptr = N - 1;
    m_ov  = 0;
    m_od  = 8'h00;
    m_oi  = 3'd0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  task automatic m_eval();
    m_load = !m_ov || t_rdy_in;
    m_any  = 0;
    m_sel  = 0;
    for (int k = 1; k <= N; k++) begin
      int j = (m_ptr + k) % N;
      if (!m_any && t_v[j]) begin
        m_any = 1;
        m_sel = j;
      end
    end
    m_rdy = (m_load && m_any) ? 8'(1 << m_sel) : 8'h00;
  endtask

  task automatic m_commit();
    if (m_load) begin
      if (m_any) begin
        m_ov  = 1;
        m_od  = t_d[m_sel];
        m_oi  = 3'(m_sel);
        m_ptr = m_sel;
        if (m_cnt[m_sel] < 65535) m_cnt[m_sel]++;
      end else begin
        m_ov = 0;
      end
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (o_valid !== 1'b0 || o_idx !== 3'd0 || o_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_state: got v=%b idx=%0d d=%h want 0/0/00",
               o_valid, o_idx, o_data);
    end
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      t_v = 8'hFF;
      t_rdy_in = 1'b1;
      for (int i = 0; i < N; i++) t_d[i] = 8'($urandom);
      #1;
      m_eval();
      total++;
      if (rv !== m_rdy) begin
        bad++;
        $display("FAIL reset_rdy: got %b want %b", rv, m_rdy);
      end
      @(posedge clk);
      m_commit();
      #2;
      if (c == 0) begin
        total++;
        if (o_valid !== 1'b1 || o_idx !== 3'd0) begin
          bad++;
          $display("FAIL reset_first_grant: got v=%b idx=%0d want 1/0",
                   o_valid, o_idx);
        end
      end
    end
    rst = 1'b1;
    #1;
    total++;
    if (o_valid !== 1'b0 || o_idx !== 3'd0) begin
      bad++;
      $display("FAIL reset_async: got v=%b idx=%0d want 0/0",
               o_valid, o_idx);
    end
    m_reset();
    t_v = 8'h00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_rotate();
    for (int c = 0; c < 9; c++) begin
      t_v = 8'hFF;
      t_rdy_in = 1'b1;
      for (int i = 0; i < N; i++) t_d[i] = 8'(8'h10 + i);
      #1;
      m_eval();
      total++;
      if (rv !== m_rdy) begin
        bad++;
        $display("FAIL rotate_rdy: got %b want %b", rv, m_rdy);
      end
      @(posedge clk);
      m_commit();
      #2;
      total++;
      if (o_valid !== 1'b1 || o_idx !== 3'(c % N) ||
          o_data !== 8'(8'h10 + c % N)) begin
        bad++;
        $display("FAIL rotate_beat%0d: got v=%b idx=%0d d=%h want 1/%0d/%h",
                 c, o_valid, o_idx, o_data, c % N, 8'h10 + c % N);
      end
    end
  endtask

  task automatic test_wrap();
    for (int c = 0; c < 5; c++) begin
      t_rdy_in = 1'b1;
      if (c == 0) begin
        t_v = 8'h40;
        t_d[6] = 8'h66;
      end else begin
        t_v = 8'h20;
        t_d[5] = 8'hA5;
      end
      #1;
      m_eval();
      total++;
      if (rv !== m_rdy) begin
        bad++;
        $display("FAIL wrap_rdy: got %b want %b", rv, m_rdy);
      end
      @(posedge clk);
      m_commit();
      #2;
      if (c > 0) begin
        total++;
        if (o_valid !== 1'b1 || o_idx !== 3'd5 || o_data !== 8'hA5) begin
          bad++;
          $display("FAIL wrap_beat: got v=%b idx=%0d d=%h want 1/5/a5",
                   o_valid, o_idx, o_data);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] cap_i;
    logic [7:0] cap_d;
    for (int i = 0; i < N; i++) t_d[i] = 8'(8'h30 + i);
    t_v = 8'hFF;
    for (int c = 0; c < 2; c++) begin
      t_rdy_in = 1'b1;
      #1;
      m_eval();
      @(posedge clk);
      m_commit();
      #2;
    end
    cap_i = o_idx;
    cap_d = o_data;
    total++;
    if (o_valid !== m_ov || o_idx !== m_oi || o_data !== m_od) begin
      bad++;
      $display("FAIL bp_pre: got v=%b idx=%0d d=%h want %b/%0d/%h",
               o_valid, o_idx, o_data, m_ov, m_oi, m_od);
    end
    for (int c = 0; c < 4; c++) begin
      t_rdy_in = 1'b0;
      #1;
      m_eval();
      total++;
      if (rv !== 8'h00) begin
        bad++;
        $display("FAIL bp_rdy_low: got %b want 00000000", rv);
      end
      @(posedge clk);
      m_commit();
      #2;
      total++;
      if (o_valid !== 1'b1 || o_idx !== cap_i || o_data !== cap_d) begin
        bad++;
        $display("FAIL bp_hold: got v=%b idx=%0d d=%h want 1/%0d/%h",
                 o_valid, o_idx, o_data, cap_i, cap_d);
      end
    end
    t_rdy_in = 1'b1;
    #1;
    m_eval();
    total++;
    if (rv !== 8'(1 << ((int'(cap_i) + 1) % N))) begin
      bad++;
      $display("FAIL bp_release_rdy: got %b want idx %0d",
               rv, (int'(cap_i) + 1) % N);
    end
    @(posedge clk);
    m_commit();
    #2;
    total++;
    if (o_idx !== 3'((int'(cap_i) + 1) % N) || o_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_release_beat: got idx=%0d want %0d",
               o_idx, (int'(cap_i) + 1) % N);
    end
  endtask

  task automatic test_drop();
    t_d[1] = 8'h01;
    t_d[2] = 8'h22;
    t_d[3] = 8'h33;
    for (int c = 0; c < 5; c++) begin
      t_rdy_in = 1'b1;
      if (c == 0)      t_v = 8'h02;
      else if (c == 1) t_v = 8'h0C;
      else             t_v = 8'h04;
      #1;
      m_eval();
      total++;
      if (rv !== m_rdy) begin
        bad++;
        $display("FAIL drop_rdy: got %b want %b", rv, m_rdy);
      end
      @(posedge clk);
      m_commit();
      #2;
      if (c > 0) begin
        total++;
        if (o_valid !== 1'b1 || o_idx !== 3'd2 || o_data !== 8'h22) begin
          bad++;
          $display("FAIL drop_beat: got v=%b idx=%0d d=%h want 1/2/22",
                   o_valid, o_idx, o_data);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] hs = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (t_v[i] && !hs[i]) begin
          if ($urandom_range(9) == 0) t_v[i] = 1'b0;
        end else begin
          t_v[i] = ($urandom_range(2) != 0);
          t_d[i] = 8'($urandom);
        end
      end
      t_rdy_in = ($urandom_range(9) < 7);
      #1;
      m_eval();
      hs = m_rdy;
      total++;
      if (rv !== m_rdy) begin
        bad++;
        $display("FAIL rand_rdy@%0d: got %b want %b", c, rv, m_rdy);
      end
      @(posedge clk);
      m_commit();
      #2;
      total++;
      if (o_valid !== m_ov || o_idx !== m_oi || o_data !== m_od) begin
        bad++;
        $display("FAIL rand_beat@%0d: got v=%b idx=%0d d=%h want %b/%0d/%h",
                 c, o_valid, o_idx, o_data, m_ov, m_oi, m_od);
      end
    end
`ifdef SVI_ARB_CNT_EN
    for (int i = 0; i < N; i++) begin
      total++;
      if (o_cnt[i*16 +: 16] !== 16'(m_cnt[i])) begin
        bad++;
        $display("FAIL rand_cnt%0d: got %0d want %0d",
                 i, o_cnt[i*16 +: 16], m_cnt[i]);
      end
    end
`endif
  endtask

`ifdef SVI_ARB_CNT_EN
  task automatic test_counter();
    rst = 1'b1;
    t_v = 8'h00;
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    t_v = 8'h02;
    t_d[1] = 8'h5A;
    t_rdy_in = 1'b1;
    for (int c = 0; c < 70000; c++) begin
      #1;
      m_eval();
      @(posedge clk);
      m_commit();
      #2;
    end
    for (int i = 0; i < N; i++) begin
      total++;
      if (o_cnt[i*16 +: 16] !== ((i == 1) ? 16'hFFFF : 16'h0000) ||
          o_cnt[i*16 +: 16] !== 16'(m_cnt[i])) begin
        bad++;
        $display("FAIL cnt_sat%0d: got %h want %h",
                 i, o_cnt[i*16 +: 16], (i == 1) ? 16'hFFFF : 16'h0000);
      end
    end
    rst = 1'b1;
    #1;
    m_reset();
    total++;
    if (o_cnt !== '0) begin
      bad++;
      $display("FAIL cnt_reset: got %h want 0", o_cnt);
    end
    t_v = 8'h00;
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < N; i++) t_d[i] = 8'h00;
    test_reset();
    test_rotate();
    test_wrap();
    test_backpressure();
    test_drop();
    test_random();
`ifdef SVI_ARB_CNT_EN
    test_counter();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
